// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, mem-stage and memory-macro signals around the data-memory port arbiter.
// The master side stands for the requesters and the memory macro. The slave side is the arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ma_req;
  logic        ma_wen;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdat;
  logic        ma_gnt;
  logic        ma_rvalid;
  logic [31:0] ma_rdata;

  logic        mem_cs;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dat_in;
  logic [31:0] mem_dat_out;

  modport master (
    output if_req, if_addr, ma_req, ma_wen, ma_addr, ma_wdat, mem_dat_out,
    input  if_gnt, if_rvalid, if_rdata, ma_gnt, ma_rvalid, ma_rdata,
           mem_cs, mem_wen, mem_addr, mem_dat_in
  );

  modport slave (
    input  if_req, if_addr, ma_req, ma_wen, ma_addr, ma_wdat, mem_dat_out,
    output if_gnt, if_rvalid, if_rdata, ma_gnt, ma_rvalid, ma_rdata,
           mem_cs, mem_wen, mem_addr, mem_dat_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data memory between fetch and the memory-access stage.
// Grants are combinational. Read data is returned to the read's owner after RD_LAT cycles.
module mem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int LW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic { IDLE, RD_WAIT } state_t;
  typedef enum logic { OWN_MA, OWN_IF } owner_t;

  state_t          state;
  owner_t          owner;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;

  logic            if_win;
  logic            ma_win;
  logic            rd_done;
  logic            starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // Fetch can only override the mem stage after STARVE_MAX consecutive refusals.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    if_win  = 1'b0;
    ma_win  = 1'b0;
    rd_done = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        if (starved && bus.if_req)  if_win = 1'b1;
        else if (bus.ma_req)        ma_win = 1'b1;
        else if (bus.if_req)        if_win = 1'b1;
      end else begin
        rd_done = (lat_cnt == LW'(1));
      end
    end
  end

  assign bus.if_gnt     = if_win;
  assign bus.ma_gnt     = ma_win;
  assign bus.mem_cs     = if_win | ma_win;
  assign bus.mem_wen    = ma_win & bus.ma_wen;
  assign bus.mem_addr   = ma_win ? bus.ma_addr : (if_win ? bus.if_addr : '0);
  assign bus.mem_dat_in = ma_win ? bus.ma_wdat : '0;

  assign bus.if_rvalid  = rd_done && (owner == OWN_IF);
  assign bus.ma_rvalid  = rd_done && (owner == OWN_MA);
  assign bus.if_rdata   = bus.if_rvalid ? bus.mem_dat_out : '0;
  assign bus.ma_rdata   = bus.ma_rvalid ? bus.mem_dat_out : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_MA;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Stores complete in the grant cycle. Only reads hold the port.
          if (if_win || (ma_win && !bus.ma_wen)) begin
            owner   <= if_win ? OWN_IF : OWN_MA;
            lat_cnt <= LW'(RD_LAT);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - LW'(1);
          if (lat_cnt == LW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (if_win)
        starve_cnt <= '0;
      else if (bus.if_req && !starved)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances (RD_LAT=1/STARVE_MAX=4 and RD_LAT=3/STARVE_MAX=2) share one stimulus stream.
// Outputs are checked against a deadline-based reference model and a behavioural memory.
module tb_mem_port_arbiter;

  localparam int LAT0 = 1, SM0 = 4, LAT1 = 3, SM1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if b0 ();
  mem_port_arbiter_if b1 ();

  mem_port_arbiter #(.RD_LAT(LAT0), .STARVE_MAX(SM0)) u_l1 (.clk(clk), .rst(rst), .bus(b0));
  mem_port_arbiter #(.RD_LAT(LAT1), .STARVE_MAX(SM1)) u_l3 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ma_gnt;
    logic        ma_rvalid;
    logic [31:0] ma_rdata;
    logic        mem_cs;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
  } obs_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        rst_v, if_req_v, ma_req_v, ma_wen_v;
  logic [31:0] if_addr_v, ma_addr_v, ma_wdat_v;

  int          lat_k [2];
  int          sm_k  [2];
  int          busy_end [2];   // cycle in which the outstanding read returns, -1 when the port is free
  int          starve   [2];
  bit          owner_if [2];
  logic [31:0] exp_rd   [2];
  logic [31:0] exp_mem  [2][256];
  logic [31:0] env_mem  [2][256];
  int          env_due  [2];
  logic [31:0] env_dat  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input int k, input obs_t act);
    obs_t e;
    int   win;
    string p;
    e   = '0;
    win = 0;
    p   = $sformatf("u%0d.", k);
    if (rst_v) begin
      busy_end[k] = -1;
      starve[k]   = 0;
    end else begin
      if (busy_end[k] >= 0) begin
        if (cyc == busy_end[k]) begin
          if (owner_if[k]) begin e.if_rvalid = 1'b1; e.if_rdata = exp_rd[k]; end
          else             begin e.ma_rvalid = 1'b1; e.ma_rdata = exp_rd[k]; end
          busy_end[k] = -1;
        end
      end else begin
        if (starve[k] == sm_k[k] && if_req_v) win = 1;
        else if (ma_req_v)                   win = 2;
        else if (if_req_v)                   win = 1;
        if (win == 1) begin
          e.if_gnt   = 1'b1;
          e.mem_cs   = 1'b1;
          e.mem_addr = if_addr_v;
          owner_if[k] = 1'b1;
          exp_rd[k]   = exp_mem[k][if_addr_v[9:2]];
          busy_end[k] = cyc + lat_k[k];
        end else if (win == 2) begin
          e.ma_gnt     = 1'b1;
          e.mem_cs     = 1'b1;
          e.mem_addr   = ma_addr_v;
          e.mem_wen    = ma_wen_v;
          e.mem_dat_in = ma_wdat_v;
          if (ma_wen_v) exp_mem[k][ma_addr_v[9:2]] = ma_wdat_v;
          else begin
            owner_if[k] = 1'b0;
            exp_rd[k]   = exp_mem[k][ma_addr_v[9:2]];
            busy_end[k] = cyc + lat_k[k];
          end
        end
      end
      if (e.if_gnt)                             starve[k] = 0;
      else if (if_req_v && starve[k] < sm_k[k]) starve[k]++;
    end

    check({p, "if_gnt"},     32'(act.if_gnt),    32'(e.if_gnt));
    check({p, "if_rvalid"},  32'(act.if_rvalid), 32'(e.if_rvalid));
    check({p, "if_rdata"},   act.if_rdata,       e.if_rdata);
    check({p, "ma_gnt"},     32'(act.ma_gnt),    32'(e.ma_gnt));
    check({p, "ma_rvalid"},  32'(act.ma_rvalid), 32'(e.ma_rvalid));
    check({p, "ma_rdata"},   act.ma_rdata,       e.ma_rdata);
    check({p, "mem_cs"},     32'(act.mem_cs),    32'(e.mem_cs));
    check({p, "mem_wen"},    32'(act.mem_wen),   32'(e.mem_wen));
    check({p, "mem_addr"},   act.mem_addr,       e.mem_addr);
    check({p, "mem_dat_in"}, act.mem_dat_in,     e.mem_dat_in);

    // The memory macro reacts to what the DUT actually drove.
    if (act.mem_cs === 1'b1) begin
      if (act.mem_wen === 1'b1) env_mem[k][act.mem_addr[9:2]] = act.mem_dat_in;
      else begin
        env_due[k] = cyc + lat_k[k];
        env_dat[k] = env_mem[k][act.mem_addr[9:2]];
      end
    end
  endtask

  task automatic step();
    obs_t a0, a1;
    @(negedge clk);
    rst = rst_v;
    b0.if_req = if_req_v;  b0.if_addr = if_addr_v;
    b0.ma_req = ma_req_v;  b0.ma_wen  = ma_wen_v;  b0.ma_addr = ma_addr_v;  b0.ma_wdat = ma_wdat_v;
    b1.if_req = if_req_v;  b1.if_addr = if_addr_v;
    b1.ma_req = ma_req_v;  b1.ma_wen  = ma_wen_v;  b1.ma_addr = ma_addr_v;  b1.ma_wdat = ma_wdat_v;
    b0.mem_dat_out = (env_due[0] == cyc) ? env_dat[0] : $urandom();
    b1.mem_dat_out = (env_due[1] == cyc) ? env_dat[1] : $urandom();
    #1;
    a0 = {b0.if_gnt, b0.if_rvalid, b0.if_rdata, b0.ma_gnt, b0.ma_rvalid, b0.ma_rdata,
          b0.mem_cs, b0.mem_wen, b0.mem_addr, b0.mem_dat_in};
    a1 = {b1.if_gnt, b1.if_rvalid, b1.if_rdata, b1.ma_gnt, b1.ma_rvalid, b1.ma_rdata,
          b1.mem_cs, b1.mem_wen, b1.mem_addr, b1.mem_dat_in};
    model(0, a0);
    model(1, a1);
    cyc++;
  endtask

  task automatic idle(input int n);
    rst_v = 1'b0; if_req_v = 1'b0; ma_req_v = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    lat_k = '{LAT0, LAT1};
    sm_k  = '{SM0, SM1};
    for (int k = 0; k < 2; k++) begin
      busy_end[k] = -1; starve[k] = 0; owner_if[k] = 1'b0; exp_rd[k] = '0;
      env_due[k] = -1;  env_dat[k] = '0;
      for (int i = 0; i < 256; i++) begin
        exp_mem[k][i] = $urandom();
        env_mem[k][i] = exp_mem[k][i];
      end
      exp_mem[k][64]  = 32'h0000_CAFE;  env_mem[k][64]  = 32'h0000_CAFE;
      exp_mem[k][192] = 32'h1234_5678;  env_mem[k][192] = 32'h1234_5678;
    end
    rst_v = 1'b1; if_req_v = 1'b0; ma_req_v = 1'b0; ma_wen_v = 1'b0;
    if_addr_v = '0; ma_addr_v = '0; ma_wdat_v = '0;
    b0.if_req = 1'b0; b0.ma_req = 1'b0; b0.ma_wen = 1'b0; b0.if_addr = '0; b0.ma_addr = '0;
    b0.ma_wdat = '0; b0.mem_dat_out = '0;
    b1.if_req = 1'b0; b1.ma_req = 1'b0; b1.ma_wen = 1'b0; b1.if_addr = '0; b1.ma_addr = '0;
    b1.ma_wdat = '0; b1.mem_dat_out = '0;

    // Reset held two cycles with both requests up.
    if_req_v = 1'b1; if_addr_v = 32'h104;
    ma_req_v = 1'b1; ma_wen_v = 1'b1; ma_addr_v = 32'h200; ma_wdat_v = 32'h0BAD_0001;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst.mem_cs", 32'(b0.mem_cs), 0);
      check("rst.gnt",    32'({b0.if_gnt, b0.ma_gnt}), 0);
    end
    rst_v = 1'b0;
    step();
    check("rst.first_ma_gnt", 32'(b0.ma_gnt), 1);
    check("rst.first_if_gnt", 32'(b0.if_gnt), 0);

    // Fetch read alone on the RD_LAT=1 instance.
    ma_req_v = 1'b0; if_req_v = 1'b1; if_addr_v = 32'h100;
    step();
    check("fetch.gnt",  32'(b0.if_gnt), 1);
    check("fetch.cs",   32'(b0.mem_cs), 1);
    check("fetch.addr", b0.mem_addr, 32'h100);
    if_req_v = 1'b0;
    step();
    check("fetch.rvalid", 32'(b0.if_rvalid), 1);
    check("fetch.rdata",  b0.if_rdata, 32'h0000_CAFE);
    ma_req_v = 1'b1; ma_wen_v = 1'b1; ma_addr_v = 32'h3FC; ma_wdat_v = 32'h1;
    step();
    check("fetch.next_gnt", 32'(b0.ma_gnt), 1);
    idle(4);

    // Conflict followed by starvation on the STARVE_MAX=4 instance.
    if_req_v = 1'b1; if_addr_v = 32'h104;
    ma_req_v = 1'b1; ma_wen_v = 1'b1; ma_addr_v = 32'h40; ma_wdat_v = 32'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        check("conf.mem_wen",  32'(b0.mem_wen), 1);
        check("conf.dat_in",   b0.mem_dat_in, 32'h55);
        check("conf.addr",     b0.mem_addr, 32'h40);
      end
      if (i < 4) begin
        check("starve.ma_gnt", 32'(b0.ma_gnt), 1);
        check("starve.if_gnt", 32'(b0.if_gnt), 0);
      end else begin
        check("starve.forced_if_gnt", 32'(b0.if_gnt), 1);
        check("starve.forced_ma_gnt", 32'(b0.ma_gnt), 0);
      end
    end
    idle(6);
    if_req_v = 1'b1; ma_req_v = 1'b1;
    step();
    check("starve.cleared", 32'(b0.ma_gnt), 1);
    idle(6);

    // MA load on the RD_LAT=3 instance, fetch waiting behind it.
    ma_req_v = 1'b1; ma_wen_v = 1'b0; ma_addr_v = 32'h300;
    step();
    check("lat3.ma_gnt", 32'(b1.ma_gnt), 1);
    ma_req_v = 1'b0; if_req_v = 1'b1; if_addr_v = 32'h108;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("lat3.if_blocked", 32'(b1.if_gnt), 0);
      check("lat3.ma_rvalid",  32'(b1.ma_rvalid), (i == 3) ? 1 : 0);
      if (i == 3) check("lat3.ma_rdata", b1.ma_rdata, 32'h1234_5678);
    end
    step();
    check("lat3.if_gnt", 32'(b1.if_gnt), 1);
    idle(6);

    // Reset lands in the first wait cycle of an RD_LAT=3 load.
    ma_req_v = 1'b1; ma_wen_v = 1'b0; ma_addr_v = 32'h300;
    step();
    check("rstmid.ma_gnt", 32'(b1.ma_gnt), 1);
    rst_v = 1'b1; ma_req_v = 1'b0;
    step();
    check("rstmid.rvalid_in_rst", 32'(b1.ma_rvalid), 0);
    rst_v = 1'b0; ma_req_v = 1'b1; ma_wen_v = 1'b1; ma_addr_v = 32'h44; ma_wdat_v = 32'h77;
    step();
    check("rstmid.new_gnt", 32'(b1.ma_gnt), 1);
    ma_req_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid.no_rvalid", 32'(b1.ma_rvalid), 0);
    end
    idle(4);

    // Random traffic, including occasional resets.
    for (int n = 0; n < 2000; n++) begin
      rst_v     = ($urandom_range(0, 99) == 0);
      if_req_v  = $urandom_range(0, 1) == 1;
      ma_req_v  = $urandom_range(0, 1) == 1;
      ma_wen_v  = $urandom_range(0, 1) == 1;
      if_addr_v = 32'($urandom_range(0, 255)) << 2;
      ma_addr_v = 32'($urandom_range(0, 255)) << 2;
      ma_wdat_v = $urandom();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
